// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the end-of-test monitor.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [31:0] GP_PASS    = 32'd1;
  localparam int          HART_IDX_W = 3;

  function automatic logic gp_is_pass(input logic [31:0] gp_val);
    return gp_val == GP_PASS;
  endfunction

endpackage

// File: rtl/test_hart_tracker.sv
// Per-hart sticky exit flag; pulses first_exit (and bad_gp) on the first qualifying exit.
module test_hart_tracker
  import test_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_exit,
  input  logic [31:0] i_gp,
  output logic        o_exited,
  output logic        o_first_exit,
  output logic        o_bad_gp
);

  logic r_exited;

  assign o_first_exit = i_en & i_exit & ~r_exited;
  assign o_bad_gp     = o_first_exit & ~gp_is_pass(i_gp);
  assign o_exited     = r_exited;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exited <= 1'b0;
    end else if (i_clear) begin
      r_exited <= 1'b0;
    end else if (o_first_exit) begin
      r_exited <= 1'b1;
    end
  end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: riscv-tests gp verdict per hart, cycle timeout, sticky result.
// Define TEST_MONITOR_FIRST_FAIL_ONLY_EN to end the test on the first failing exit.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int NHARTS         = 1,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NHARTS-1:0]     exit,
  input  logic [32*NHARTS-1:0]  gp,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [HART_IDX_W-1:0] fail_hart,
  output logic [30:0]           fail_testnum,
  output logic [NHARTS-1:0]     exited,
  output logic [CNT_W-1:0]      cycles
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_timeout;
  logic                  r_fail_seen;
  logic [HART_IDX_W-1:0] r_fail_hart;
  logic [30:0]           r_fail_num;
  logic [CNT_W-1:0]      r_cycles;

  logic                  w_run;
  logic [NHARTS-1:0]     w_first;
  logic [NHARTS-1:0]     w_bad;
  logic [NHARTS-1:0]     w_exited;
  logic                  w_all_exited;
  logic                  w_any_bad;
  logic                  w_failed;
  logic                  w_at_limit;
  logic [HART_IDX_W-1:0] w_bad_idx;
  logic [30:0]           w_bad_num;

  assign w_run = (r_state == ST_RUN);

  for (genvar i = 0; i < NHARTS; i++) begin : g_hart
    test_hart_tracker u_trk (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (clear),
      .i_en         (w_run),
      .i_exit       (exit[i]),
      .i_gp         (gp[32*i +: 32]),
      .o_exited     (w_exited[i]),
      .o_first_exit (w_first[i]),
      .o_bad_gp     (w_bad[i])
    );
  end

  // Descending scan so the lowest failing hart index is the one that sticks.
  always_comb begin
    w_bad_idx = '0;
    w_bad_num = '0;
    for (int i = NHARTS - 1; i >= 0; i--) begin
      if (w_bad[i]) begin
        w_bad_idx = HART_IDX_W'(i);
        w_bad_num = gp[32*i+1 +: 31];
      end
    end
  end

  assign w_all_exited = &(w_exited | w_first);
  assign w_any_bad    = |w_bad;
  assign w_failed     = r_fail_seen | w_any_bad;
  assign w_at_limit   = (r_cycles == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN) begin
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
      if (w_any_bad) begin
        w_state_nxt = ST_FAIL;
      end else if (w_all_exited) begin
        w_state_nxt = ST_PASS;
      end else if (w_at_limit) begin
        w_state_nxt = ST_TIMEOUT;
      end
`else
      if (w_all_exited) begin
        w_state_nxt = w_failed ? ST_FAIL : ST_PASS;
      end else if (w_at_limit) begin
        w_state_nxt = ST_TIMEOUT;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_seen <= 1'b0;
      r_fail_hart <= '0;
      r_fail_num  <= '0;
      r_cycles    <= '0;
    end else if (clear) begin
      r_state     <= ST_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_seen <= 1'b0;
      r_fail_hart <= '0;
      r_fail_num  <= '0;
      r_cycles    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= (w_state_nxt != ST_RUN);
      r_pass    <= (w_state_nxt == ST_PASS);
      // A recorded failure stays visible alongside a timeout verdict.
      r_fail    <= (w_state_nxt == ST_FAIL) | ((w_state_nxt == ST_TIMEOUT) & w_failed);
      r_timeout <= (w_state_nxt == ST_TIMEOUT);
      if (w_any_bad && !r_fail_seen) begin
        r_fail_seen <= 1'b1;
        r_fail_hart <= w_bad_idx;
        r_fail_num  <= w_bad_num;
      end
      if (w_state_nxt == ST_RUN) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign fail_hart    = r_fail_hart;
  assign fail_testnum = r_fail_num;
  assign exited       = w_exited;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_test_monitor.sv
// Directed scoreboard bench: one single-hart and one four-hart monitor sharing clk/rst.
module tb_test_monitor;

  typedef struct {
    string       tag;
    logic        d;
    logic        p;
    logic        f;
    logic        t;
    logic [2:0]  h;
    logic [30:0] n;
    logic [3:0]  ex;
    logic [31:0] c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear1 = 1'b0;
  logic         clear4 = 1'b0;
  logic [0:0]   exit1 = '0;
  logic [31:0]  gp1 = '0;
  logic [3:0]   exit4 = '0;
  logic [127:0] gp4 = '0;

  logic         d1, p1, f1, t1;
  logic [2:0]   fh1;
  logic [30:0]  fn1;
  logic [0:0]   ex1;
  logic [31:0]  cy1;
  logic         d4, p4, f4, t4;
  logic [2:0]   fh4;
  logic [30:0]  fn4;
  logic [3:0]   ex4;
  logic [7:0]   cy4;

  exp_t sb1[$];
  exp_t sb4[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  test_monitor #(.NHARTS(1), .TIMEOUT_CYCLES(200), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .clear(clear1), .exit(exit1), .gp(gp1),
    .done(d1), .pass(p1), .fail(f1), .timeout(t1),
    .fail_hart(fh1), .fail_testnum(fn1), .exited(ex1), .cycles(cy1)
  );

  test_monitor #(.NHARTS(4), .TIMEOUT_CYCLES(50), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .clear(clear4), .exit(exit4), .gp(gp4),
    .done(d4), .pass(p4), .fail(f4), .timeout(t4),
    .fail_hart(fh4), .fail_testnum(fn4), .exited(ex4), .cycles(cy4)
  );

  function automatic exp_t mk(input string tag, input logic d, input logic p, input logic f,
                              input logic t, input logic [2:0] h, input logic [30:0] n,
                              input logic [3:0] ex, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.d = d; e.p = p; e.f = f; e.t = t;
    e.h = h; e.n = n; e.ex = ex; e.c = c;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic chk(input exp_t e, input logic d, input logic p, input logic f, input logic t,
                     input logic [2:0] h, input logic [30:0] n, input logic [3:0] ex,
                     input logic [31:0] c);
    a(e.tag, "done", {31'b0, d}, {31'b0, e.d});
    a(e.tag, "pass", {31'b0, p}, {31'b0, e.p});
    a(e.tag, "fail", {31'b0, f}, {31'b0, e.f});
    a(e.tag, "timeout", {31'b0, t}, {31'b0, e.t});
    a(e.tag, "fail_hart", {29'b0, h}, {29'b0, e.h});
    a(e.tag, "fail_testnum", {1'b0, n}, {1'b0, e.n});
    a(e.tag, "exited", {28'b0, ex}, {28'b0, e.ex});
    a(e.tag, "cycles", c, e.c);
  endtask

  task automatic cmp1();
    n_assert++;
    assert (sb1.size() > 0) else begin
      n_fail++;
      $error("FAIL sb1_empty observed=0 expected=1");
    end
    if (sb1.size() > 0) chk(sb1.pop_front(), d1, p1, f1, t1, fh1, fn1, {3'b0, ex1}, cy1);
  endtask

  task automatic cmp4();
    n_assert++;
    assert (sb4.size() > 0) else begin
      n_fail++;
      $error("FAIL sb4_empty observed=0 expected=1");
    end
    if (sb4.size() > 0) chk(sb4.pop_front(), d4, p4, f4, t4, fh4, fn4, ex4, {24'b0, cy4});
  endtask

  initial begin
    // Reset state
    tick(2);
    sb1.push_back(mk("rst1", 0, 0, 0, 0, 0, 0, 0, 0));
    sb4.push_back(mk("rst4", 0, 0, 0, 0, 0, 0, 0, 0));
    cmp1(); cmp4();
    rst = 1'b0;
    sb4.push_back(mk("u4_pre_tmo", 0, 0, 0, 0, 0, 0, 0, 49));
    sb4.push_back(mk("u4_tmo", 1, 0, 0, 1, 0, 0, 0, 49));
    tick(49); cmp4();
    tick(1);  cmp4();

    // Single hart pass at cycle 100
    tick(50);
    sb1.push_back(mk("u1_run100", 0, 0, 0, 0, 0, 0, 0, 100));
    cmp1();
    exit1 = 1'b1; gp1 = 32'd1;
    sb1.push_back(mk("pass100", 1, 1, 0, 0, 0, 0, 1, 100));
    tick(1); cmp1();
    gp1 = 32'hB; exit4 = 4'hF; gp4 = {4{32'd1}};
    sb1.push_back(mk("pass_sticky", 1, 1, 0, 0, 0, 0, 1, 100));
    sb4.push_back(mk("u4_tmo_sticky", 1, 0, 0, 1, 0, 0, 0, 49));
    tick(1); cmp1(); cmp4();
    exit1 = 1'b0; exit4 = '0;

    // Single hart fail with gp=0xB
    clear1 = 1'b1;
    sb1.push_back(mk("clr1", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear1 = 1'b0; cmp1();
    exit1 = 1'b1; gp1 = 32'hB;
    sb1.push_back(mk("fail_b", 1, 0, 1, 0, 0, 5, 1, 0));
    tick(1); exit1 = 1'b0; cmp1();

    // Clear coincident with an exit discards the exit; then pass counted from clear
    clear1 = 1'b1; exit1 = 1'b1; gp1 = 32'd1;
    sb1.push_back(mk("clr_exit", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear1 = 1'b0; exit1 = 1'b0; cmp1();
    tick(3);
    exit1 = 1'b1;
    sb1.push_back(mk("pass_after_clr", 1, 1, 0, 0, 0, 0, 1, 3));
    tick(1); exit1 = 1'b0; cmp1();

    // Single hart timeout boundary
    clear1 = 1'b1;
    sb1.push_back(mk("clr2", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear1 = 1'b0; cmp1();
    tick(199);
    sb1.push_back(mk("u1_pre_tmo", 0, 0, 0, 0, 0, 0, 0, 199));
    cmp1();
    sb1.push_back(mk("u1_tmo", 1, 0, 0, 1, 0, 0, 0, 199));
    tick(1); cmp1();
    exit1 = 1'b1; gp1 = 32'd1;
    sb1.push_back(mk("u1_tmo_sticky", 1, 0, 0, 1, 0, 0, 0, 199));
    tick(1); exit1 = 1'b0; cmp1();
    clear1 = 1'b1;
    sb1.push_back(mk("clr3", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear1 = 1'b0; cmp1();
    tick(199);
    exit1 = 1'b1; gp1 = 32'd1;
    sb1.push_back(mk("pass199", 1, 1, 0, 0, 0, 0, 1, 199));
    tick(1); exit1 = 1'b0; cmp1();

    // Four harts: hart 2 missing -> timeout
    clear4 = 1'b1;
    sb4.push_back(mk("clr4", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear4 = 1'b0; cmp4();
    tick(2);
    exit4 = 4'b1011; gp4 = {4{32'd1}};
    sb4.push_back(mk("u4_three", 0, 0, 0, 0, 0, 0, 4'b1011, 3));
    tick(1); cmp4();
    tick(46);
    sb4.push_back(mk("u4_pre_tmo2", 0, 0, 0, 0, 0, 0, 4'b1011, 49));
    cmp4();
    sb4.push_back(mk("u4_tmo2", 1, 0, 0, 1, 0, 0, 4'b1011, 49));
    tick(1); cmp4();

    // Four harts: hart 2 arrives late but before timeout -> pass
    clear4 = 1'b1;
    sb4.push_back(mk("clr5", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear4 = 1'b0; cmp4();
    sb4.push_back(mk("u4_three2", 0, 0, 0, 0, 0, 0, 4'b1011, 1));
    tick(1); cmp4();
    tick(9);
    exit4 = 4'b1111;
    sb4.push_back(mk("u4_pass", 1, 1, 0, 0, 0, 0, 4'b1111, 10));
    tick(1); exit4 = '0; cmp4();

    // Harts 1 and 3 fail together; lowest index reported
    clear4 = 1'b1;
    sb4.push_back(mk("clr6", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear4 = 1'b0; cmp4();
    gp4 = {32'd9, 32'h15, 32'd7, 32'd1};
    exit4 = 4'b1010;
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
    sb4.push_back(mk("u4_two_bad", 1, 0, 1, 0, 1, 3, 4'b1010, 0));
`else
    sb4.push_back(mk("u4_two_bad", 0, 0, 0, 0, 1, 3, 4'b1010, 1));
`endif
    tick(1); cmp4();
    exit4 = 4'b1011;
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
    sb4.push_back(mk("u4_h0", 1, 0, 1, 0, 1, 3, 4'b1010, 0));
`else
    sb4.push_back(mk("u4_h0", 0, 0, 0, 0, 1, 3, 4'b1011, 2));
`endif
    tick(1); cmp4();
    exit4 = 4'b1111;
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
    sb4.push_back(mk("u4_h2", 1, 0, 1, 0, 1, 3, 4'b1010, 0));
`else
    sb4.push_back(mk("u4_h2", 1, 0, 1, 0, 1, 3, 4'b1111, 2));
`endif
    tick(1); exit4 = '0; cmp4();

    // Recorded failure then timeout
    clear4 = 1'b1;
    sb4.push_back(mk("clr7", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear4 = 1'b0; cmp4();
    gp4 = {32'd1, 32'd5, 32'd1, 32'd1};
    exit4 = 4'b0100;
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
    sb4.push_back(mk("u4_bad2", 1, 0, 1, 0, 2, 2, 4'b0100, 0));
`else
    sb4.push_back(mk("u4_bad2", 0, 0, 0, 0, 2, 2, 4'b0100, 1));
`endif
    tick(1); exit4 = '0; cmp4();
    tick(48);
`ifdef TEST_MONITOR_FIRST_FAIL_ONLY_EN
    sb4.push_back(mk("u4_ft_pre", 1, 0, 1, 0, 2, 2, 4'b0100, 0));
    sb4.push_back(mk("u4_ft", 1, 0, 1, 0, 2, 2, 4'b0100, 0));
`else
    sb4.push_back(mk("u4_ft_pre", 0, 0, 0, 0, 2, 2, 4'b0100, 49));
    sb4.push_back(mk("u4_ft", 1, 0, 1, 1, 2, 2, 4'b0100, 49));
`endif
    cmp4();
    tick(1); cmp4();

    // Asynchronous reset mid-run discards partial progress
    clear4 = 1'b1;
    sb4.push_back(mk("clr8", 0, 0, 0, 0, 0, 0, 0, 0));
    tick(1); clear4 = 1'b0; cmp4();
    exit4 = 4'b0001;
    sb4.push_back(mk("u4_h0only", 0, 0, 0, 0, 0, 0, 4'b0001, 1));
    tick(1); exit4 = '0; cmp4();
    #2 rst = 1'b1;
    sb1.push_back(mk("arst1", 0, 0, 0, 0, 0, 0, 0, 0));
    sb4.push_back(mk("arst4", 0, 0, 0, 0, 0, 0, 0, 0));
    #1 cmp1(); cmp4();
    tick(1);
    rst = 1'b0;
    sb1.push_back(mk("post_rst1", 0, 0, 0, 0, 0, 0, 0, 5));
    sb4.push_back(mk("post_rst4", 0, 0, 0, 0, 0, 0, 0, 5));
    tick(5); cmp1(); cmp4();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
